tristate_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one tri-state bus between N output-enabled drivers (mux-with-OE cells). It issues a one-hot output enable and a binary select per tenure, limits tenure length, and inserts guaranteed all-OE-low turnaround cycles between tenures so two drivers never fight on the bus. It sits between the requesting units and the OE/select pins of the bus drivers.

---
 rtl/tristate_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: one-hot OE per tenure,
// bounded tenure length, and guaranteed all-OE-low turnaround between tenures.
module tristate_bus_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned MAX_HOLD    = 8,
    parameter int unsigned TURN_CYCLES = 1,
    localparam int unsigned SW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  oe,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] sel,
    output logic          busy
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam int unsigned TW = $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [N-1:0]  grant_nx;
    logic [SW-1:0] sel_nx;
    logic [SW-1:0] ptr, ptr_nx;
    logic [HW-1:0] hold, hold_nx;
    logic [TW-1:0] turn, turn_nx;
    logic          busy_nx;

    logic          found;
    logic [SW-1:0] win;
    logic [N-1:0]  win_onehot;
    logic [SW-1:0] sel_inc;
    int unsigned   idx;

    // Drivers take OE straight from the grant register, so both always agree.
    assign oe = grant;

    // First requester at or above the pointer, wrapping; index kept below N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < int'(N); i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[SW'(idx)]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
    end

    assign sel_inc = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);

    // Next-state and registered-output decode.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        sel_nx   = sel;
        ptr_nx   = ptr;
        hold_nx  = hold;
        turn_nx  = turn;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    grant_nx = win_onehot;
                    sel_nx   = win;
                    hold_nx  = HW'(1);
                end
            end
            GRANT: begin
                if (!req[sel] || hold == HW'(MAX_HOLD)) begin
                    state_nx = TURN;
                    grant_nx = '0;
                    ptr_nx   = sel_inc;
                    hold_nx  = '0;
                    turn_nx  = TW'(1);
                end else begin
                    hold_nx = hold + HW'(1);
                end
            end
            TURN: begin
                if (turn == TW'(TURN_CYCLES)) begin
                    turn_nx = '0;
                    if (found) begin
                        state_nx = GRANT;
                        grant_nx = win_onehot;
                        sel_nx   = win;
                        hold_nx  = HW'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    turn_nx = turn + TW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                hold_nx  = '0;
                turn_nx  = '0;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // Async reset releases the bus immediately, even mid-tenure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= '0;
            hold  <= '0;
            turn  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
            hold  <= hold_nx;
            turn  <= turn_nx;
            busy  <= busy_nx;
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: default instance plus a
// TURN_CYCLES=3 instance for turnaround timing.
module tb_tristate_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req, req3;
    logic [3:0] oe, grant, oe3, grant3;
    logic [1:0] sel, sel3;
    logic       busy, busy3;

    int tests;
    int fails;

    tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req),
        .oe(oe), .grant(grant), .sel(sel), .busy(busy)
    );

    tristate_bus_arbiter #(.N(4), .MAX_HOLD(4), .TURN_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3),
        .oe(oe3), .grant(grant3), .sel(sel3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus-safety invariants every cycle on both instances.
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot_oe", 32'($countones(oe) <= 1), 32'(1));
            chk("onehot_oe3", 32'($countones(oe3) <= 1), 32'(1));
            chk("oe_eq_grant", 32'(oe), 32'(grant));
            chk("oe3_eq_grant3", 32'(oe3), 32'(grant3));
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req   = 4'b1111;
        req3  = 4'b0000;

        // Reset with all requests high
        step();
        step();
        chk("rst_oe", 32'(oe), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        req = 4'b0000;
        rst = 1'b0;
        step();
        chk("idle_oe", 32'(oe), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Single request on requester 2
        req = 4'b0100;
        step();
        chk("single_oe", 32'(oe), 32'h4);
        chk("single_sel", 32'(sel), 32'h2);
        chk("single_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        chk("single_turn_oe", 32'(oe), 32'h0);
        chk("single_turn_busy", 32'(busy), 32'h1);
        chk("single_turn_sel", 32'(sel), 32'h2);
        step();
        chk("single_idle_busy", 32'(busy), 32'h0);
        chk("single_idle_oe", 32'(oe), 32'h0);

        // Pointer now 3: grant 3, then wrap to 0, then back to 3
        req = 4'b1000;
        step();
        chk("wrap_g3", 32'(oe), 32'h8);
        req = 4'b0001;
        step();
        chk("wrap_turn", 32'(oe), 32'h0);
        req = 4'b1001;
        step();
        chk("wrap_g0", 32'(oe), 32'h1);
        chk("wrap_g0_sel", 32'(sel), 32'h0);
        req = 4'b1000;
        step();
        chk("wrap_turn2", 32'(oe), 32'h0);
        step();
        chk("wrap_g3b", 32'(oe), 32'h8);
        chk("wrap_g3b_sel", 32'(sel), 32'h3);
        req = 4'b0000;
        step();
        step();
        chk("wrap_idle", 32'(busy), 32'h0);

        // Round robin, all requesting; pointer is 0
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) begin
                chk("rr_oe", 32'(oe), 32'(4'b0001 << (k % 4)));
                chk("rr_sel", 32'(sel), 32'(k % 4));
                step();
            end
            chk("rr_turn_oe", 32'(oe), 32'h0);
            chk("rr_turn_busy", 32'(busy), 32'h1);
            step();
        end
        chk("rr_next", 32'(oe), 32'h2);
        req = 4'b0000;
        step();
        step();
        chk("rr_idle", 32'(busy), 32'h0);

        // Tenure limit with a lone requester: re-granted after each turnaround
        req = 4'b0010;
        step();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 8; c++) begin
                chk("hold_oe", 32'(oe), 32'h2);
                step();
            end
            chk("hold_turn_oe", 32'(oe), 32'h0);
            step();
        end
        chk("hold_regrant", 32'(oe), 32'h2);
        step();
        chk("hold_regrant2", 32'(oe), 32'h2);
        req = 4'b0000;
        step();
        chk("hold_rel_turn", 32'(oe), 32'h0);
        step();
        chk("hold_rel_idle", 32'(busy), 32'h0);

        // Reset mid-tenure drops the bus immediately
        req = 4'b0100;
        step();
        chk("mid_grant", 32'(oe), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", 32'(oe), 32'h0);
        chk("mid_rst_sel", 32'(sel), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;
        req = 4'b0000;
        step();
        chk("post_rst_idle", 32'(busy), 32'h0);
        req = 4'b1111;
        step();
        chk("post_rst_ptr0", 32'(oe), 32'h1);
        req = 4'b0000;
        step();
        step();
        chk("post_rst_end", 32'(busy), 32'h0);

        // Three-cycle turnaround on the second instance
        req3 = 4'b0001;
        step();
        chk("t3_g0", 32'(oe3), 32'h1);
        req3 = 4'b0101;
        step();
        chk("t3_g0_hold", 32'(oe3), 32'h1);
        req3 = 4'b0100;
        step();
        for (int c = 0; c < 3; c++) begin
            chk("t3_turn_oe", 32'(oe3), 32'h0);
            chk("t3_turn_busy", 32'(busy3), 32'h1);
            chk("t3_turn_sel", 32'(sel3), 32'h0);
            step();
        end
        chk("t3_g2", 32'(oe3), 32'h4);
        chk("t3_g2_sel", 32'(sel3), 32'h2);
        req3 = 4'b0000;
        step();
        step();
        step();
        chk("t3_turn_tail", 32'(busy3), 32'h1);
        step();
        chk("t3_idle", 32'(busy3), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
